// File: rtl/parking_pkg.sv
// Shared definitions for the car-park entry controller.
//   STATE_W            width of the FSM state register
//   IDLE .. LOCKOUT    state encodings (LOCKOUT is only reachable when the
//                      controller is built with LOCKOUT_EN defined)
//   is_pw_state()      true in the states that wait for a password submission
package parking_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE           = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_PASSWORD  = 3'd1;
  localparam logic [STATE_W-1:0] WRONG_PASSWORD = 3'd2;
  localparam logic [STATE_W-1:0] RIGHT_PASSWORD = 3'd3;
  localparam logic [STATE_W-1:0] STOP           = 3'd4;
  localparam logic [STATE_W-1:0] LOCKOUT        = 3'd5;

  function automatic logic is_pw_state(input logic [STATE_W-1:0] s);
    return (s == WAIT_PASSWORD) || (s == WRONG_PASSWORD);
  endfunction

endpackage

// File: rtl/parking_blink_div.sv
// Free-running blink phase generator for the status LEDs.
// The phase flips once every BLINK_DIV clock cycles, starting low after reset.
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   phase_o  out  blink phase
module parking_blink_div #(
  parameter int BLINK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic phase_o
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park entry controller: password-gated barrier with occupancy tracking.
// A Moore FSM admits one car per visit after a correct two-digit password,
// refuses visits when the park is full, abandons a visit after TIMEOUT idle
// cycles and flags tailgating (entrance and exit sensors both active).
// All outputs are registered, so LEDs and gate_open trail the state by one cycle.
// Optional build macro LOCKOUT_EN: after MAX_TRIES wrong submissions in one
// visit the controller locks out for LOCK_CYCLES cycles, then returns to IDLE.
// Ports:
//   clk, reset_n                      clock / asynchronous active-low reset
//   entrance_sensor_input             car present at the entrance
//   exit_sensor_input                 car has passed the barrier
//   car_leave                         one-cycle pulse, a parked car left
//   password_1, password_2, pw_valid  password digits and submit strobe
//   GREEN_LED, RED_LED                status LEDs
//   gate_open                         barrier open (RIGHT_PASSWORD)
//   full, occupancy                   occupancy status
//   state_o                           current state, for debug
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int              CAPACITY    = 8,
  parameter int              PW_W        = 2,
  parameter logic [PW_W-1:0] PASSWORD_1  = 2'b01,
  parameter logic [PW_W-1:0] PASSWORD_2  = 2'b10,
  parameter int              WAIT_CYCLES = 4,
  parameter int              TIMEOUT     = 64,
  parameter int              BLINK_DIV   = 2,
  parameter int              MAX_TRIES   = 3,
  parameter int              LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          entrance_sensor_input,
  input  logic                          exit_sensor_input,
  input  logic                          car_leave,
  input  logic [PW_W-1:0]               password_1,
  input  logic [PW_W-1:0]               password_2,
  input  logic                          pw_valid,
  output logic                          GREEN_LED,
  output logic                          RED_LED,
  output logic                          gate_open,
  output logic                          full,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic [STATE_W-1:0]            state_o
);

  localparam int OCC_W  = $clog2(CAPACITY + 1);
  localparam int WAIT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int TO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [OCC_W-1:0]  OCC_MAX  = OCC_W'(CAPACITY);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               full_q, full_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               green_q, green_d;
  logic               red_q, red_d;
  logic               gate_q, gate_d;

  logic               blink;
  logic               pw_ok;
  logic               accept;
  logic               timed_out;
  logic               admit;
  logic               wrong_sub;
  logic [STATE_W-1:0] reject_st;

`ifdef LOCKOUT_EN
  localparam int TRY_W  = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  logic [TRY_W-1:0]  try_q, try_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{MAX_TRIES, LOCK_CYCLES, LOCKOUT};
`endif

  parking_blink_div #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .phase_o (blink)
  );

  // Next-state logic
  always_comb begin
    pw_ok     = (password_1 == PASSWORD_1) && (password_2 == PASSWORD_2);
    // Submissions arriving before the minimum dwell in WAIT_PASSWORD are dropped.
    accept    = pw_valid && (wait_q >= WAIT_MAX);
    timed_out = !pw_valid && (to_q == TO_LAST);
    admit     = 1'b0;
    wrong_sub = 1'b0;
    state_d   = state_q;
`ifdef LOCKOUT_EN
    // The submission that reaches MAX_TRIES goes straight to LOCKOUT.
    reject_st = (try_q >= TRY_LAST) ? LOCKOUT : WRONG_PASSWORD;
`else
    reject_st = WRONG_PASSWORD;
`endif

    case (state_q)
      IDLE: begin
        if (entrance_sensor_input && !full_q) state_d = WAIT_PASSWORD;
      end
      WAIT_PASSWORD: begin
        if (accept) begin
          if (pw_ok) begin
            state_d = RIGHT_PASSWORD;
          end else begin
            state_d   = reject_st;
            wrong_sub = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      WRONG_PASSWORD: begin
        if (pw_valid) begin
          if (pw_ok) begin
            state_d = RIGHT_PASSWORD;
          end else begin
            state_d   = reject_st;
            wrong_sub = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      RIGHT_PASSWORD: begin
        // Both sensors active means a second car is following through.
        if (entrance_sensor_input && exit_sensor_input) begin
          state_d = STOP;
        end else if (exit_sensor_input) begin
          state_d = IDLE;
          admit   = 1'b1;
        end
      end
      STOP: begin
        if (pw_valid && pw_ok) state_d = RIGHT_PASSWORD;
      end
`ifdef LOCKOUT_EN
      LOCKOUT: begin
        if (lock_q == LOCK_LAST) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Dwell, timeout and lockout counters
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == WAIT_PASSWORD) && (wait_q < WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Any strobe restarts the timeout, even one dropped by the dwell check.
    to_d = to_q;
    if ((state_d != state_q) || pw_valid) begin
      to_d = '0;
    end else if (is_pw_state(state_q) && (to_q != TO_LAST)) begin
      to_d = to_q + TO_W'(1);
    end

`ifdef LOCKOUT_EN
    try_d = try_q;
    if ((state_q == IDLE) || (state_q == RIGHT_PASSWORD)) begin
      try_d = '0;
    end else if (wrong_sub && (try_q < TRY_W'(MAX_TRIES))) begin
      try_d = try_q + TRY_W'(1);
    end

    lock_d = lock_q;
    if (state_d != state_q) begin
      lock_d = '0;
    end else if ((state_q == LOCKOUT) && (lock_q != LOCK_LAST)) begin
      lock_d = lock_q + LOCK_W'(1);
    end
`endif
  end

  // Occupancy: an admission and a departure in the same cycle cancel out.
  always_comb begin
    occ_d = occ_q;
    if (admit && car_leave) begin
      occ_d = occ_q;
    end else if (admit) begin
      if (occ_q != OCC_MAX) occ_d = occ_q + OCC_W'(1);
    end else if (car_leave && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
    full_d = (occ_d == OCC_MAX);
  end

  // Output decode from the current state
  always_comb begin
    gate_d  = (state_q == RIGHT_PASSWORD);
    green_d = 1'b0;
    red_d   = 1'b0;
    case (state_q)
      IDLE:           red_d   = full_q;
      WAIT_PASSWORD:  red_d   = 1'b1;
      WRONG_PASSWORD: red_d   = blink;
      STOP:           red_d   = blink;
      RIGHT_PASSWORD: green_d = blink;
`ifdef LOCKOUT_EN
      LOCKOUT: begin
        red_d   = 1'b1;
        green_d = blink;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      occ_q   <= '0;
      full_q  <= 1'b0;
      wait_q  <= '0;
      to_q    <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      gate_q  <= 1'b0;
`ifdef LOCKOUT_EN
      try_q   <= '0;
      lock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      green_q <= green_d;
      red_q   <= red_d;
      gate_q  <= gate_d;
`ifdef LOCKOUT_EN
      try_q   <= try_d;
      lock_q  <= lock_d;
`endif
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign gate_open = gate_q;
  assign full      = full_q;
  assign occupancy = occ_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

  localparam int         CAP    = 2;
  localparam logic [1:0] PW1    = 2'b01;
  localparam logic [1:0] PW2    = 2'b10;
  localparam int         WAITC  = 4;
  localparam int         TO     = 64;
  localparam int         BD     = 2;
  localparam int         MAXT   = 3;
  localparam int         LOCKC  = 16;
  localparam int         OCC_W  = $clog2(CAP + 1);

  logic             clk;
  logic             reset_n;
  logic             entrance, exit_s, leave, pwv;
  logic [1:0]       pw1, pw2;
  logic             GREEN_LED, RED_LED, gate_open, full;
  logic [OCC_W-1:0] occupancy;
  logic [2:0]       state_o;

  int n_checks;
  int n_fail;

  // Reference model: state as spec numbers, time kept as cycle stamps.
  int cyc, m_st, m_entry, m_ref, m_occ, m_tries;
  bit m_green, m_red, m_gate;

  parking_gate_ctrl #(
    .CAPACITY(CAP), .PW_W(2), .PASSWORD_1(PW1), .PASSWORD_2(PW2),
    .WAIT_CYCLES(WAITC), .TIMEOUT(TO), .BLINK_DIV(BD),
    .MAX_TRIES(MAXT), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .entrance_sensor_input(entrance), .exit_sensor_input(exit_s),
    .car_leave(leave), .password_1(pw1), .password_2(pw2), .pw_valid(pwv),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .gate_open(gate_open),
    .full(full), .occupancy(occupancy), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_init();
    cyc = 0; m_st = 0; m_entry = 0; m_ref = 0; m_occ = 0; m_tries = 0;
    m_green = 0; m_red = 0; m_gate = 0;
  endtask

  task automatic model_step(input logic ent, input logic ex, input logic lv,
                            input logic [1:0] p1, input logic [1:0] p2, input logic v);
    int c, nst;
    bit ph, fl, match, inc;
    c     = cyc;
    ph    = ((c / BD) % 2) == 1;
    fl    = (m_occ == CAP);
    match = (p1 == PW1) && (p2 == PW2);
    m_gate  = (m_st == 3);
    m_green = (m_st == 3 || m_st == 5) ? ph : 1'b0;
    if (m_st == 0)                    m_red = fl;
    else if (m_st == 1 || m_st == 5)  m_red = 1'b1;
    else if (m_st == 2 || m_st == 4)  m_red = ph;
    else                              m_red = 1'b0;
    nst = m_st;
    inc = 0;
    case (m_st)
      0: if (ent && !fl) nst = 1;
      1, 2: begin
        if (v) begin
          if (m_st == 1 && (c - m_entry) < WAITC) begin
            m_ref = c + 1;
          end else if (match) begin
            nst = 3;
          end else begin
            m_ref = c + 1;
            nst = 2;
`ifdef LOCKOUT_EN
            m_tries++;
            if (m_tries >= MAXT) nst = 5;
`endif
          end
        end else if ((c - m_ref) >= TO - 1) begin
          nst = 0;
        end
      end
      3: if (ent && ex) nst = 4; else if (ex) begin nst = 0; inc = 1; end
      4: if (v && match) nst = 3;
      5: if ((c - m_entry) >= LOCKC - 1) nst = 0;
      default: nst = 0;
    endcase
    if (inc && lv) begin
      m_occ = m_occ;
    end else if (inc) begin
      if (m_occ < CAP) m_occ++;
    end else if (lv && m_occ > 0) begin
      m_occ--;
    end
    if (nst == 0 || nst == 3) m_tries = 0;
    if (nst != m_st) begin
      m_entry = c + 1;
      m_ref   = c + 1;
    end
    m_st = nst;
    cyc++;
  endtask

  function automatic logic [8:0] model_pack();
    return {3'(m_st), OCC_W'(m_occ), (m_occ == CAP), m_green, m_red, m_gate};
  endfunction

  task automatic tick(input logic ent, input logic ex, input logic lv,
                      input logic [1:0] p1, input logic [1:0] p2, input logic v);
    entrance = ent; exit_s = ex; leave = lv; pw1 = p1; pw2 = p2; pwv = v;
    model_step(ent, ex, lv, p1, p2, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(0, 0, 0, 2'b00, 2'b00, 0);
  endtask

  task automatic go_right();
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    repeat (WAITC) idle();
    tick(0, 0, 0, PW1, PW2, 1);
  endtask

  task automatic test_reset();
    reset_n = 0; entrance = 0; exit_s = 0; leave = 0; pw1 = 0; pw2 = 0; pwv = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({state_o, occupancy, full, GREEN_LED, RED_LED, gate_open} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {state_o, occupancy, full, GREEN_LED, RED_LED, gate_open});
    end
    reset_n = 1;
    model_init();
    idle();
    n_checks++;
    if ({state_o, occupancy, full, GREEN_LED, RED_LED, gate_open} !== 9'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 0", {state_o, occupancy, full, GREEN_LED, RED_LED, gate_open});
    end
  endtask

  task automatic test_entry();
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL entry_wait: got %0d expected 1", state_o); end
    idle();
    tick(0, 0, 0, PW1, PW2, 1);
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL early_pw_ignored: got %0d expected 1", state_o); end
    idle(); idle();
    n_checks++;
    if (RED_LED !== 1'b1) begin n_fail++; $display("FAIL wait_red: got %b expected 1", RED_LED); end
    tick(0, 0, 0, PW1, PW2, 1);
    n_checks++;
    if (state_o !== 3'd3 || gate_open !== 1'b0) begin
      n_fail++; $display("FAIL right_state: got state %0d gate %b expected state 3 gate 0", state_o, gate_open);
    end
    idle();
    n_checks++;
    if (gate_open !== 1'b1) begin n_fail++; $display("FAIL gate_open: got %b expected 1", gate_open); end
    tick(0, 1, 0, 2'b00, 2'b00, 0);
    n_checks++;
    if (state_o !== 3'd0 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL exit_admit: got state %0d occ %0d expected state 0 occ 1", state_o, occupancy);
    end
  endtask

  task automatic test_full();
    go_right();
    tick(0, 1, 0, 2'b00, 2'b00, 0);
    n_checks++;
    if (occupancy !== 2'd2 || full !== 1'b1) begin
      n_fail++; $display("FAIL full_flag: got occ %0d full %b expected occ 2 full 1", occupancy, full);
    end
    idle();
    n_checks++;
    if (RED_LED !== 1'b1) begin n_fail++; $display("FAIL full_red: got %b expected 1", RED_LED); end
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL full_refuse: got %0d expected 0", state_o); end
    tick(0, 0, 1, 2'b00, 2'b00, 0);
    n_checks++;
    if (occupancy !== 2'd1 || full !== 1'b0) begin
      n_fail++; $display("FAIL car_leave: got occ %0d full %b expected occ 1 full 0", occupancy, full);
    end
    idle();
    n_checks++;
    if (RED_LED !== 1'b0) begin n_fail++; $display("FAIL not_full_red: got %b expected 0", RED_LED); end
  endtask

  task automatic test_wrong_blink();
    int toggles;
    logic prev;
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    repeat (WAITC) idle();
    tick(0, 0, 0, 2'b11, 2'b00, 1);
    n_checks++;
    if (state_o !== 3'd2) begin n_fail++; $display("FAIL wrong_state: got %0d expected 2", state_o); end
    idle();
    prev = RED_LED;
    toggles = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      n_checks++;
      if (RED_LED !== m_red) begin n_fail++; $display("FAIL wrong_blink[%0d]: got %b expected %b", i, RED_LED, m_red); end
      if (RED_LED !== prev) toggles++;
      prev = RED_LED;
    end
    n_checks++;
    if (toggles < 3) begin n_fail++; $display("FAIL blink_toggles: got %0d expected at least 3", toggles); end
    tick(0, 0, 0, PW1, PW2, 1);
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL wrong_to_right: got %0d expected 3", state_o); end
    tick(0, 1, 0, 2'b00, 2'b00, 0);
    tick(0, 0, 1, 2'b00, 2'b00, 0);
  endtask

  task automatic test_timeout();
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    repeat (TO - 1) idle();
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL timeout_early: got %0d expected 1", state_o); end
    idle();
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL wait_timeout: got %0d expected 0", state_o); end
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    repeat (WAITC) idle();
    tick(0, 0, 0, 2'b11, 2'b00, 1);
    repeat (TO - 1) idle();
    n_checks++;
    if (state_o !== 3'd2) begin n_fail++; $display("FAIL wrong_timeout_early: got %0d expected 2", state_o); end
    idle();
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL wrong_timeout: got %0d expected 0", state_o); end
  endtask

  task automatic test_stop();
    go_right();
    tick(1, 1, 0, 2'b00, 2'b00, 0);
    n_checks++;
    if (state_o !== 3'd4) begin n_fail++; $display("FAIL tailgate_stop: got %0d expected 4", state_o); end
    for (int i = 0; i < 4; i++) begin
      idle();
      n_checks++;
      if (RED_LED !== m_red || GREEN_LED !== 1'b0) begin
        n_fail++; $display("FAIL stop_leds[%0d]: got red %b green %b expected red %b green 0", i, RED_LED, GREEN_LED, m_red);
      end
    end
    tick(0, 0, 0, 2'b11, 2'b00, 1);
    n_checks++;
    if (state_o !== 3'd4) begin n_fail++; $display("FAIL stop_wrong_pw: got %0d expected 4", state_o); end
    tick(0, 0, 0, PW1, PW2, 1);
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL stop_to_right: got %0d expected 3", state_o); end
    tick(0, 1, 1, 2'b00, 2'b00, 0);
    n_checks++;
    if (state_o !== 3'd0 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL exit_and_leave: got state %0d occ %0d expected state 0 occ 1", state_o, occupancy);
    end
    tick(0, 0, 1, 2'b00, 2'b00, 0);
    tick(0, 0, 1, 2'b00, 2'b00, 0);
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL leave_at_zero: got %0d expected 0", occupancy); end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    idle(); idle();
    n_checks++;
    if (state_o !== 3'd1 || RED_LED !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_wait: got state %0d red %b expected state 1 red 1", state_o, RED_LED);
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({state_o, occupancy, full, GREEN_LED, RED_LED, gate_open} !== 9'd0) begin
      n_fail++; $display("FAIL async_reset: got %b expected 0", {state_o, occupancy, full, GREEN_LED, RED_LED, gate_open});
    end
    @(negedge clk);
    reset_n = 1;
    model_init();
  endtask

`ifdef LOCKOUT_EN
  task automatic test_lockout();
    tick(1, 0, 0, 2'b00, 2'b00, 0);
    repeat (WAITC) idle();
    repeat (MAXT) tick(0, 0, 0, 2'b11, 2'b00, 1);
    n_checks++;
    if (state_o !== 3'd5) begin n_fail++; $display("FAIL lockout_enter: got %0d expected 5", state_o); end
    tick(0, 0, 0, PW1, PW2, 1);
    n_checks++;
    if (state_o !== 3'd5 || RED_LED !== 1'b1) begin
      n_fail++; $display("FAIL lockout_ignore: got state %0d red %b expected state 5 red 1", state_o, RED_LED);
    end
    repeat (LOCKC - 2) idle();
    n_checks++;
    if (state_o !== 3'd5) begin n_fail++; $display("FAIL lockout_hold: got %0d expected 5", state_o); end
    idle();
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL lockout_exit: got %0d expected 0", state_o); end
  endtask
`endif

  task automatic test_random();
    logic ent, ex, lv, v;
    logic [1:0] p1, p2;
    for (int i = 0; i < 3000; i++) begin
      ent = ($urandom_range(99) < 30);
      ex  = ($urandom_range(99) < 20);
      lv  = ($urandom_range(99) < 10);
      v   = ($urandom_range(99) < 12);
      if ($urandom_range(1) == 1) begin
        p1 = PW1; p2 = PW2;
      end else begin
        p1 = 2'($urandom); p2 = 2'($urandom);
      end
      tick(ent, ex, lv, p1, p2, v);
      n_checks++;
      if ({state_o, occupancy, full, GREEN_LED, RED_LED, gate_open} !== model_pack()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b expected %b (state,occ,full,green,red,gate)",
                 i, {state_o, occupancy, full, GREEN_LED, RED_LED, gate_open}, model_pack());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_init();
    test_reset();
    test_entry();
    test_full();
    test_wrong_blink();
    test_timeout();
    test_stop();
    test_async_reset();
`ifdef LOCKOUT_EN
    test_lockout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
